j_fetch_engine: RTL and testbench

Parametrised coupling-fetch unit between `top_control` and an array of SPUs. It replaces the single combinational J-matrix lookup and single 16-deep J FIFO with a sequential engine. The engine accepts row-segment fetch commands, streams `JW`-bit couplings from a synchronous coupling memory at one word per cycle, and pushes them into one of `NCH` per-SPU first-word-fall-through FIFOs, or into all of them in broadcast mode. Credit-based issue guarantees the FIFOs never overflow.

---
 rtl/j_fetch_engine.sv | 210 +++++++++++++++++++++
 tb/tb_j_fetch_engine.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/j_fetch_engine.sv
// rtl/j_fetch_engine.sv - credit-based coupling fetch engine feeding per-SPU FWFT FIFOs
module j_fetch_engine #(
  parameter int NCH   = 4,
  parameter int JW    = 4,
  parameter int DEPTH = 16,
  parameter int RW    = 16,
  parameter int LW    = 16,
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CHW-1:0]    cmd_ch,
  input  logic              cmd_bcast,
  input  logic [RW-1:0]     cmd_row,
  input  logic [RW-1:0]     cmd_col,
  input  logic [LW-1:0]     cmd_len,
  output logic              mem_rd_en,
  output logic [RW-1:0]     mem_row,
  output logic [RW-1:0]     mem_col,
  input  logic [JW-1:0]     mem_data,
  input  logic [NCH-1:0]    spu_rd_en,
  output logic [NCH*JW-1:0] spu_j,
  output logic [NCH-1:0]    spu_empty,
  output logic              busy,
  output logic              done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  // Latched command; col_q doubles as the running read address.
  logic [RW-1:0]  row_q;
  logic [RW-1:0]  col_q;
  logic [LW-1:0]  rem_q;
  logic [CHW-1:0] ch_q;
  logic           bcast_q;

  // The read issued last cycle, whose data arrives on mem_data this cycle.
  logic           rd_q;
  logic [CHW-1:0] rd_ch_q;
  logic           rd_bcast_q;

  logic           accept;
  logic           credit_ok;
  logic [NCH-1:0] tgt;
  logic [NCH-1:0] credit;
  logic [NCH-1:0] push;
  logic [NCH-1:0] pop;

  assign mem_row = row_q;
  assign mem_col = col_q;

  // Credit for the current command: every channel when broadcasting, else the target channel.
  always_comb begin
    credit_ok = 1'b0;
    if (bcast_q) begin
      credit_ok = &credit;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (ch_q == CHW'(c)) begin
          credit_ok = credit[c];
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and control outputs; flush overrides every transition and strobe.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    accept    = 1'b0;
    mem_rd_en = 1'b0;
    done      = 1'b0;
    busy      = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        cmd_ready = ~flush;
        if (cmd_valid && !flush) begin
          accept  = 1'b1;
          state_d = (cmd_len == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (credit_ok && !flush) begin
          mem_rd_en = 1'b1;
          if (rem_q == LW'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = ~flush;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (flush) begin
      state_d = S_IDLE;
    end
  end

  // Command latch, address/remaining counters and the one-deep in-flight read record.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q      <= '0;
      col_q      <= '0;
      rem_q      <= '0;
      ch_q       <= '0;
      bcast_q    <= 1'b0;
      rd_q       <= 1'b0;
      rd_ch_q    <= '0;
      rd_bcast_q <= 1'b0;
    end else if (flush) begin
      rd_q       <= 1'b0;
    end else begin
      if (accept) begin
        row_q   <= cmd_row;
        col_q   <= cmd_col;
        rem_q   <= cmd_len;
        ch_q    <= cmd_ch;
        bcast_q <= cmd_bcast;
      end else if (mem_rd_en) begin
        col_q   <= col_q + RW'(1);
        rem_q   <= rem_q - LW'(1);
      end
      rd_q       <= mem_rd_en;
      rd_ch_q    <= ch_q;
      rd_bcast_q <= bcast_q;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [JW-1:0] store [DEPTH];
    logic [AW-1:0] wp_q;
    logic [AW-1:0] rp_q;
    logic [CW-1:0] count_q;
    logic [CW:0]   occ;

    // The in-flight read is counted against this channel before it lands, so a
    // FIFO can never be offered more words than it has room for.
    assign tgt[c]    = rd_bcast_q | (rd_ch_q == CHW'(c));
    assign occ       = {1'b0, count_q} + {{CW{1'b0}}, rd_q & tgt[c]};
    assign credit[c] = (occ < (CW+1)'(DEPTH));
    assign push[c]   = rd_q & tgt[c] & ~flush;
    assign pop[c]    = spu_rd_en[c] & (count_q != '0) & ~flush;

    // Pointer and occupancy bookkeeping; a pop on an empty FIFO is masked above.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wp_q    <= '0;
        rp_q    <= '0;
        count_q <= '0;
      end else if (flush) begin
        wp_q    <= '0;
        rp_q    <= '0;
        count_q <= '0;
      end else begin
        if (push[c]) begin
          wp_q <= wp_q + AW'(1);
        end
        if (pop[c]) begin
          rp_q <= rp_q + AW'(1);
        end
        if (push[c] && !pop[c]) begin
          count_q <= count_q + CW'(1);
        end else if (!push[c] && pop[c]) begin
          count_q <= count_q - CW'(1);
        end
      end
    end

    // Storage array; contents are don't-care whenever count_q says so.
    always_ff @(posedge clk) begin
      if (push[c]) begin
        store[wp_q] <= mem_data;
      end
    end

    assign spu_empty[c]      = (count_q == '0);
    assign spu_j[c*JW +: JW] = (count_q != '0) ? store[rp_q] : '0;
  end

endmodule

// File: tb/tb_j_fetch_engine.sv
// tb/tb_j_fetch_engine.sv - randomized self-checking bench for j_fetch_engine
module tb_j_fetch_engine;

  localparam int NCH   = 4;
  localparam int JW    = 4;
  localparam int DEPTH = 16;
  localparam int RW    = 16;
  localparam int LW    = 16;
  localparam int CHW   = 2;

  logic              clk       = 1'b0;
  logic              rst       = 1'b1;
  logic              flush     = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [CHW-1:0]    cmd_ch    = '0;
  logic              cmd_bcast = 1'b0;
  logic [RW-1:0]     cmd_row   = '0;
  logic [RW-1:0]     cmd_col   = '0;
  logic [LW-1:0]     cmd_len   = '0;
  logic              mem_rd_en;
  logic [RW-1:0]     mem_row;
  logic [RW-1:0]     mem_col;
  logic [JW-1:0]     mem_data  = '0;
  logic [NCH-1:0]    spu_rd_en = '0;
  logic [NCH*JW-1:0] spu_j;
  logic [NCH-1:0]    spu_empty;
  logic              busy;
  logic              done;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int got_q [NCH][$];
  int exp_q [NCH][$];
  int rd_row_log[$];
  int rd_col_log[$];
  int rd_cyc_log[$];
  int done_log[$];
  int exp_row[$];
  int exp_col[$];

  j_fetch_engine #(
    .NCH(NCH), .JW(JW), .DEPTH(DEPTH), .RW(RW), .LW(LW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch), .cmd_bcast(cmd_bcast),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_len(cmd_len),
    .mem_rd_en(mem_rd_en), .mem_row(mem_row), .mem_col(mem_col), .mem_data(mem_data),
    .spu_rd_en(spu_rd_en), .spu_j(spu_j), .spu_empty(spu_empty),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous coupling memory: word at (row, col) is the low JW bits of row ^ col.
  always @(posedge clk) begin
    if (mem_rd_en) mem_data <= JW'(mem_row ^ mem_col);
  end

  // Observation log, taken mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rd_en) begin
        rd_row_log.push_back(int'(mem_row));
        rd_col_log.push_back(int'(mem_col));
        rd_cyc_log.push_back(cyc);
      end
      if (done) done_log.push_back(cyc);
      for (int c = 0; c < NCH; c++) begin
        if (spu_rd_en[c] && !spu_empty[c]) got_q[c].push_back(int'(spu_j[c*JW +: JW]));
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic int mem_word(input int row, input int col);
    return (row ^ col) & ((1 << JW) - 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    for (int c = 0; c < NCH; c++) begin
      got_q[c].delete();
      exp_q[c].delete();
    end
    rd_row_log.delete();
    rd_col_log.delete();
    rd_cyc_log.delete();
    done_log.delete();
    exp_row.delete();
    exp_col.delete();
  endtask

  // Offers a command and records what the memory reads and FIFO contents must become.
  task automatic issue(input int ch, input int bcast, input int row, input int col,
                       input int len, output int t, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    t  = 0;
    while (!cmd_ready && n < 500) begin
      step();
      n++;
    end
    if (cmd_ready) begin
      cmd_valid = 1'b1;
      cmd_ch    = CHW'(ch);
      cmd_bcast = (bcast != 0);
      cmd_row   = RW'(row);
      cmd_col   = RW'(col);
      cmd_len   = LW'(len);
      t         = cyc;
      ok        = 1'b1;
      for (int i = 0; i < len; i++) begin
        int cc;
        cc = (col + i) & 16'hFFFF;
        exp_row.push_back(row);
        exp_col.push_back(cc);
        for (int c = 0; c < NCH; c++) begin
          if (bcast != 0 || c == ch) exp_q[c].push_back(mem_word(row, cc));
        end
      end
      step();
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(output bit ok);
    int n;
    n = 0;
    while (!cmd_ready && n < 1000) begin
      step();
      n++;
    end
    ok = cmd_ready;
  endtask

  task automatic drain(output bit ok);
    int n;
    n = 0;
    spu_rd_en = '1;
    while (spu_empty != '1 && n < 300) begin
      step();
      n++;
    end
    ok = (spu_empty == '1);
    spu_rd_en = '0;
    step();
  endtask

  task automatic test_reset();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
    checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_mem_rd_en: got %b required 0", mem_rd_en); end
    checks++; if (mem_row !== '0 || mem_col !== '0) begin errors++; $display("FAIL reset_addr: got %h/%h required 0/0", mem_row, mem_col); end
    checks++; if (spu_empty !== 4'hF) begin errors++; $display("FAIL reset_empty: got %b required 1111", spu_empty); end
    checks++; if (spu_j !== '0) begin errors++; $display("FAIL reset_spu_j: got %h required 0", spu_j); end
  endtask

  task automatic test_single();
    int t;
    bit ok;
    int exp_w[3];
    exp_w = '{15, 14, 9};
    clear_logs();
    issue(2, 0, 5, 10, 3, t, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_accept: got timeout required accept"); end
    step();
    checks++; if (spu_empty[2] !== 1'b1) begin errors++; $display("FAIL single_empty_T2: got %b required 1", spu_empty[2]); end
    step();
    checks++; if (spu_empty[2] !== 1'b0) begin errors++; $display("FAIL single_visible_T3: got %b required 0", spu_empty[2]); end
    checks++; if (spu_j[11:8] !== 4'hF) begin errors++; $display("FAIL single_head_T3: got %h required f", spu_j[11:8]); end
    wait_idle(ok);
    checks++; if (cyc != t + 6) begin errors++; $display("FAIL single_ready_cycle: got T+%0d required T+6", cyc - t); end
    checks++;
    if (rd_col_log.size() != 3) begin
      errors++; $display("FAIL single_read_count: got %0d required 3", rd_col_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rd_row_log[i] != 5 || rd_col_log[i] != 10 + i || rd_cyc_log[i] != t + 1 + i) begin
          errors++;
          $display("FAIL single_read%0d: got (%0d,%0d)@T+%0d required (5,%0d)@T+%0d",
                   i, rd_row_log[i], rd_col_log[i], rd_cyc_log[i] - t, 10 + i, 1 + i);
        end
      end
    end
    checks++;
    if (done_log.size() != 1 || done_log[0] != t + 5) begin
      errors++; $display("FAIL single_done: got %0d pulses first T+%0d required 1 at T+5",
                         done_log.size(), (done_log.size() > 0) ? done_log[0] - t : -1);
    end
    checks++; if (spu_empty !== 4'b1011) begin errors++; $display("FAIL single_others_empty: got %b required 1011", spu_empty); end
    drain(ok);
    checks++;
    if (got_q[2].size() != 3) begin
      errors++; $display("FAIL single_fifo_len: got %0d required 3", got_q[2].size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[2][i] != exp_w[i]) begin errors++; $display("FAIL single_word%0d: got %h required %h", i, got_q[2][i], exp_w[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    int t;
    bit ok;
    int row;
    int col;
    clear_logs();
    row = $urandom_range(0, 65535);
    col = $urandom_range(0, 65535);
    issue(0, 0, row, col, 40, t, ok);
    repeat (40) step();
    checks++; if (rd_col_log.size() != DEPTH) begin errors++; $display("FAIL bp_reads_stalled: got %0d required %0d", rd_col_log.size(), DEPTH); end
    checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL bp_rd_en_stalled: got %b required 0", mem_rd_en); end
    spu_rd_en = 4'b0001;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_complete: got timeout required idle"); end
    drain(ok);
    repeat (3) step();
    checks++; if (done_log.size() != 1) begin errors++; $display("FAIL bp_done_count: got %0d required 1", done_log.size()); end
    checks++;
    if (rd_col_log.size() != 40) begin
      errors++; $display("FAIL bp_read_total: got %0d required 40", rd_col_log.size());
    end else begin
      for (int i = 0; i < 40; i++) begin
        checks++;
        if (rd_col_log[i] != exp_col[i]) begin errors++; $display("FAIL bp_col%0d: got %h required %h", i, rd_col_log[i], exp_col[i]); end
      end
    end
    checks++;
    if (got_q[0].size() != exp_q[0].size()) begin
      errors++; $display("FAIL bp_word_total: got %0d required %0d", got_q[0].size(), exp_q[0].size());
    end else begin
      for (int i = 0; i < exp_q[0].size(); i++) begin
        checks++;
        if (got_q[0][i] != exp_q[0][i]) begin errors++; $display("FAIL bp_word%0d: got %h required %h", i, got_q[0][i], exp_q[0][i]); end
      end
    end
  endtask

  task automatic test_broadcast();
    int t;
    bit ok;
    int base;
    clear_logs();
    issue(1, 0, $urandom_range(0, 65535), $urandom_range(0, 65535), 12, t, ok);
    wait_idle(ok);
    base = rd_col_log.size();
    spu_rd_en = 4'b1101;
    issue(3, 1, $urandom_range(0, 65535), $urandom_range(0, 65535), 8, t, ok);
    repeat (30) step();
    checks++; if (rd_col_log.size() - base != 4) begin errors++; $display("FAIL bcast_stall_reads: got %0d required 4", rd_col_log.size() - base); end
    checks++; if (mem_rd_en !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL bcast_stalled: got rd_en=%b busy=%b required 0/1", mem_rd_en, busy); end
    spu_rd_en = 4'b1111;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bcast_complete: got timeout required idle"); end
    drain(ok);
    checks++; if (rd_col_log.size() != 20) begin errors++; $display("FAIL bcast_read_total: got %0d required 20", rd_col_log.size()); end
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (got_q[c].size() != exp_q[c].size()) begin
        errors++; $display("FAIL bcast_len_ch%0d: got %0d required %0d", c, got_q[c].size(), exp_q[c].size());
      end else begin
        for (int i = 0; i < exp_q[c].size(); i++) begin
          checks++;
          if (got_q[c][i] != exp_q[c][i]) begin errors++; $display("FAIL bcast_ch%0d_word%0d: got %h required %h", c, i, got_q[c][i], exp_q[c][i]); end
        end
      end
    end
  endtask

  task automatic test_wrap_zero();
    int t;
    bit ok;
    int ch;
    int exp_c[4];
    exp_c = '{16'hFFFE, 16'hFFFF, 0, 1};
    clear_logs();
    ch = $urandom_range(0, NCH - 1);
    issue(ch, 0, $urandom_range(0, 65535), 16'hFFFE, 4, t, ok);
    wait_idle(ok);
    checks++;
    if (rd_col_log.size() != 4) begin
      errors++; $display("FAIL wrap_read_count: got %0d required 4", rd_col_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rd_col_log[i] != exp_c[i]) begin errors++; $display("FAIL wrap_col%0d: got %h required %h", i, rd_col_log[i], exp_c[i]); end
      end
    end
    drain(ok);
    checks++;
    if (got_q[ch].size() != 4) begin
      errors++; $display("FAIL wrap_word_count: got %0d required 4", got_q[ch].size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_q[ch][i] != exp_q[ch][i]) begin errors++; $display("FAIL wrap_word%0d: got %h required %h", i, got_q[ch][i], exp_q[ch][i]); end
      end
    end
    clear_logs();
    issue(ch, 0, 7, 7, 0, t, ok);
    wait_idle(ok);
    checks++; if (cyc != t + 2) begin errors++; $display("FAIL zero_ready_cycle: got T+%0d required T+2", cyc - t); end
    checks++;
    if (done_log.size() != 1 || done_log[0] != t + 1) begin
      errors++; $display("FAIL zero_done: got %0d pulses first T+%0d required 1 at T+1",
                         done_log.size(), (done_log.size() > 0) ? done_log[0] - t : -1);
    end
    checks++; if (rd_col_log.size() != 0) begin errors++; $display("FAIL zero_reads: got %0d required 0", rd_col_log.size()); end
  endtask

  task automatic test_flush();
    int t;
    bit ok;
    int n;
    int ch;
    clear_logs();
    ch = $urandom_range(0, NCH - 1);
    issue(ch, 0, $urandom_range(0, 65535), $urandom_range(0, 65535), 10, t, ok);
    n = 0;
    while (rd_col_log.size() < 5 && n < 100) begin
      step();
      n++;
    end
    checks++; if (rd_col_log.size() != 5) begin errors++; $display("FAIL flush_pre_reads: got %0d required 5", rd_col_log.size()); end
    flush = 1'b1;
    #1;
    checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL flush_rd_en: got %b required 0", mem_rd_en); end
    step();
    flush = 1'b0;
    #1;
    checks++; if (spu_empty !== 4'hF) begin errors++; $display("FAIL flush_empty: got %b required 1111", spu_empty); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_done_now: got %b required 0", done); end
    for (int c = 0; c < NCH; c++) exp_q[c].delete();
    repeat (10) step();
    checks++; if (done_log.size() != 0) begin errors++; $display("FAIL flush_no_done: got %0d pulses required 0", done_log.size()); end
    checks++; if (rd_col_log.size() != 5) begin errors++; $display("FAIL flush_reads_stop: got %0d required 5", rd_col_log.size()); end
    ch = (ch + 1) % NCH;
    issue(ch, 0, $urandom_range(0, 65535), $urandom_range(0, 65535), 3, t, ok);
    wait_idle(ok);
    drain(ok);
    checks++; if (done_log.size() != 1) begin errors++; $display("FAIL flush_next_done: got %0d required 1", done_log.size()); end
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (got_q[c].size() != exp_q[c].size()) begin
        errors++; $display("FAIL flush_next_len_ch%0d: got %0d required %0d", c, got_q[c].size(), exp_q[c].size());
      end else begin
        for (int i = 0; i < exp_q[c].size(); i++) begin
          checks++;
          if (got_q[c][i] != exp_q[c][i]) begin errors++; $display("FAIL flush_next_ch%0d_word%0d: got %h required %h", c, i, got_q[c][i], exp_q[c][i]); end
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int t;
    bit ok;
    clear_logs();
    issue($urandom_range(0, NCH - 1), 0, $urandom_range(0, 65535), 16'h1234, 10, t, ok);
    repeat (4) step();
    checks++; if (spu_empty === 4'hF || busy !== 1'b1) begin errors++; $display("FAIL arst_pre: got empty=%b busy=%b required data and busy", spu_empty, busy); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || mem_rd_en !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL arst_ctrl: got busy=%b rd_en=%b ready=%b required 0/0/1", busy, mem_rd_en, cmd_ready); end
    checks++; if (spu_empty !== 4'hF || spu_j !== '0) begin errors++; $display("FAIL arst_fifo: got empty=%b j=%h required 1111/0", spu_empty, spu_j); end
    checks++; if (mem_col !== '0 || mem_row !== '0) begin errors++; $display("FAIL arst_addr: got %h/%h required 0/0", mem_row, mem_col); end
    @(negedge clk);
    #2;
    rst = 1'b0;
    repeat (2) step();
    clear_logs();
  endtask

  task automatic test_random();
    int t;
    bit ok;
    int n;
    clear_logs();
    for (int it = 0; it < 10; it++) begin
      int ch;
      int bc;
      ch = $urandom_range(0, NCH - 1);
      bc = ($urandom_range(0, 3) == 0) ? 1 : 0;
      issue(ch, bc, $urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 30), t, ok);
      n = 0;
      while (!cmd_ready && n < 2000) begin
        spu_rd_en = NCH'($urandom);
        step();
        n++;
      end
      checks++; if (!cmd_ready) begin errors++; $display("FAIL rand_cmd%0d_complete: got timeout required idle", it); end
    end
    spu_rd_en = '0;
    drain(ok);
    checks++; if (done_log.size() != 10) begin errors++; $display("FAIL rand_done_count: got %0d required 10", done_log.size()); end
    checks++;
    if (rd_col_log.size() != exp_col.size()) begin
      errors++; $display("FAIL rand_read_total: got %0d required %0d", rd_col_log.size(), exp_col.size());
    end else begin
      for (int i = 0; i < exp_col.size(); i++) begin
        checks++;
        if (rd_col_log[i] != exp_col[i] || rd_row_log[i] != exp_row[i]) begin
          errors++; $display("FAIL rand_read%0d: got (%h,%h) required (%h,%h)", i, rd_row_log[i], rd_col_log[i], exp_row[i], exp_col[i]);
        end
      end
    end
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (got_q[c].size() != exp_q[c].size()) begin
        errors++; $display("FAIL rand_len_ch%0d: got %0d required %0d", c, got_q[c].size(), exp_q[c].size());
      end else begin
        for (int i = 0; i < exp_q[c].size(); i++) begin
          checks++;
          if (got_q[c][i] != exp_q[c][i]) begin errors++; $display("FAIL rand_ch%0d_word%0d: got %h required %h", c, i, got_q[c][i], exp_q[c][i]); end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    test_reset();
    test_single();
    test_backpressure();
    test_broadcast();
    test_wrap_zero();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
